// File: rtl/fp_add_pkg.sv
// Shared constants, FSM states and the buffered entry layout for the adder operand-issue stage.
// Optional build flag: FP_ADD_DENORM_FLUSH_EN (flush denormal operands to signed zero).
package fp_add_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 1 + EXP_W + MAN_W;

   localparam logic [W-1:0]     QNAN     = 32'h7FC0_0000;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         hidden_a;
      logic         hidden_b;
      logic         special;
      logic [W-1:0] special_result;
   } entry_t;

endpackage

// File: rtl/fp_add_operand_stage_classify.sv
// Combinational unpack/classify of one operand pair into a buffer entry.
// FP_ADD_DENORM_FLUSH_EN: denormals become signed zero (mantissa forced to 0).
module fp_operand_classify
   import fp_add_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output entry_t       entry
);

   logic             sign_a, sign_b;
   logic [EXP_W-1:0] exp_a, exp_b;
   logic [MAN_W-1:0] man_a, man_b;
   logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
   logic [W-1:0]     a_f, b_f;

   always_comb begin
      sign_a = a[W-1];
      sign_b = b[W-1];
      exp_a  = a[W-2:MAN_W];
      exp_b  = b[W-2:MAN_W];
      man_a  = a[MAN_W-1:0];
      man_b  = b[MAN_W-1:0];
`ifdef FP_ADD_DENORM_FLUSH_EN
      if (exp_a == '0) man_a = '0;
      if (exp_b == '0) man_b = '0;
`endif
      a_f = {sign_a, exp_a, man_a};
      b_f = {sign_b, exp_b, man_b};

      zero_a = (exp_a == '0) && (man_a == '0);
      zero_b = (exp_b == '0) && (man_b == '0);
      inf_a  = (exp_a == EXP_ONES) && (man_a == '0);
      inf_b  = (exp_b == EXP_ONES) && (man_b == '0);
      nan_a  = (exp_a == EXP_ONES) && (man_a != '0);
      nan_b  = (exp_b == EXP_ONES) && (man_b != '0);

      entry.a              = a_f;
      entry.b              = b_f;
      entry.hidden_a       = (exp_a != '0);
      entry.hidden_b       = (exp_b != '0);
      entry.special        = 1'b1;
      entry.special_result = '0;

      // Priority: NaN, opposite infinities, infinity, zero, then ordinary add.
      if (nan_a || nan_b) begin
         entry.special_result = QNAN;
      end else if (inf_a && inf_b && (sign_a != sign_b)) begin
         entry.special_result = QNAN;
      end else if (inf_a) begin
         entry.special_result = a_f;
      end else if (inf_b) begin
         entry.special_result = b_f;
      end else if (zero_a && zero_b) begin
         entry.special_result = {sign_a & sign_b, {(W-1){1'b0}}};
      end else if (zero_a) begin
         entry.special_result = b_f;
      end else if (zero_b) begin
         entry.special_result = a_f;
      end else begin
         entry.special = 1'b0;
      end
   end

endmodule

// File: rtl/fp_add_operand_stage.sv
// Operand-issue stage feeding the combinational adder: classify at input, 2-entry skid buffer.
// FP_ADD_DENORM_FLUSH_EN selects denormal flushing inside fp_operand_classify.
module fp_add_operand_stage
   import fp_add_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_a,
   output logic [EXP_W+MAN_W:0]   out_b,
   output logic                   out_hidden_a,
   output logic                   out_hidden_b,
   output logic                   out_special,
   output logic [EXP_W+MAN_W:0]   out_special_result,
   output logic [CNT_W-1:0]       op_count
);

   // Handshake: a pair moves when valid and ready are both high on a rising edge;
   // a producer holding valid keeps its data stable until it sees ready.

   state_t           state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   entry_t           in_entry;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;
   logic             accept, pop;

   fp_operand_classify u_classify (
      .a     (in_a),
      .b     (in_b),
      .entry (in_entry)
   );

   assign accept = in_valid & in_ready_q;
   assign pop    = (state_q != EMPTY) & out_ready;

   always_comb begin
      state_d    = state_q;
      main_d     = main_q;
      skid_d     = skid_q;
      op_count_d = op_count_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               main_d = in_entry;
            end else if (accept) begin
               skid_d  = in_entry;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (pop) op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      in_ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
         op_count_q <= op_count_d;
      end
   end

   assign in_ready           = in_ready_q;
   assign out_valid          = (state_q != EMPTY);
   assign out_a              = main_q.a;
   assign out_b              = main_q.b;
   assign out_hidden_a       = main_q.hidden_a;
   assign out_hidden_b       = main_q.hidden_b;
   assign out_special        = main_q.special;
   assign out_special_result = main_q.special_result;
   assign op_count           = op_count_q;

endmodule

// File: tb/tb_fp_add_operand_stage.sv
// Directed and streamed checks of the operand-issue stage against a small reference model.
module tb_fp_add_operand_stage;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_a, out_b, out_special_result;
   logic        out_hidden_a, out_hidden_b, out_special;
   logic [15:0] op_count;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] exp_count = '0;
   logic [98:0] exp_q[$];

   fp_add_operand_stage dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_a               (in_a),
      .in_b               (in_b),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .out_a              (out_a),
      .out_b              (out_b),
      .out_hidden_a       (out_hidden_a),
      .out_hidden_b       (out_hidden_b),
      .out_special        (out_special),
      .out_special_result (out_special_result),
      .op_count           (op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [98:0] model(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y, r;
      logic        sp, za, zb, ia, ib, na, nb;
      x = a;
      y = b;
`ifdef FP_ADD_DENORM_FLUSH_EN
      if (x[30:23] == 8'h00) x[22:0] = '0;
      if (y[30:23] == 8'h00) y[22:0] = '0;
`endif
      za = (x[30:0] == 31'd0);
      zb = (y[30:0] == 31'd0);
      ia = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      ib = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
      na = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      nb = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
      sp = 1'b1;
      if (na || nb) r = QNAN;
      else if (ia && ib && (x[31] != y[31])) r = QNAN;
      else if (ia) r = x;
      else if (ib) r = y;
      else if (za && zb) r = {x[31] & y[31], 31'd0};
      else if (za) r = y;
      else if (zb) r = x;
      else begin
         sp = 1'b0;
         r  = '0;
      end
      return {x, y, x[30:23] != 8'h00, y[30:23] != 8'h00, sp, r};
   endfunction

   function automatic logic [31:0] rand_op();
      logic        s;
      logic [22:0] m;
      s = 1'($urandom_range(0, 1));
      m = 23'($urandom);
      case ($urandom_range(0, 7))
         0:       return {s, 8'h00, 23'd0};
         1:       return {s, 8'h00, m | 23'd1};
         2:       return {s, 8'hFF, 23'd0};
         3:       return {s, 8'hFF, m | 23'd1};
         default: return {s, 8'($urandom_range(1, 254)), m};
      endcase
   endfunction

   task automatic drive(input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if ({out_a, out_b, out_special_result} !== 96'd0) begin n_fail++; $display("FAIL reset_data got %h %h %h want 0", out_a, out_b, out_special_result); end
      n_cmp++; if ({out_hidden_a, out_hidden_b, out_special} !== 3'd0) begin n_fail++; $display("FAIL reset_flags got %b want 000", {out_hidden_a, out_hidden_b, out_special}); end
      n_cmp++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got %0d want 0", op_count); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      @(negedge clk);
      out_ready = 1'b1;
      drive(32'h3F80_0000, 32'h4000_0000);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
      n_cmp++; if (out_a !== 32'h3F80_0000) begin n_fail++; $display("FAIL basic_a got %h want 3f800000", out_a); end
      n_cmp++; if (out_b !== 32'h4000_0000) begin n_fail++; $display("FAIL basic_b got %h want 40000000", out_b); end
      n_cmp++; if ({out_hidden_a, out_hidden_b, out_special} !== 3'b110) begin n_fail++; $display("FAIL basic_flags got %b want 110", {out_hidden_a, out_hidden_b, out_special}); end
      n_cmp++; if (out_special_result !== 32'd0) begin n_fail++; $display("FAIL basic_result got %h want 0", out_special_result); end
      exp_count++;
      @(negedge clk);
      n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL basic_count got %0d want %0d", op_count, exp_count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", out_valid); end
   endtask

   task automatic test_infinities();
      @(negedge clk);
      drive(32'h7F80_0000, 32'hFF80_0000);
      @(negedge clk);
      drive(32'h7F80_0000, 32'h3F80_0000);
      n_cmp++; if ({out_special, out_special_result} !== {1'b1, QNAN}) begin n_fail++; $display("FAIL inf_opposite got %b %h want 1 7fc00000", out_special, out_special_result); end
      exp_count++;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if ({out_special, out_special_result} !== {1'b1, 32'h7F80_0000}) begin n_fail++; $display("FAIL inf_plus_num got %b %h want 1 7f800000", out_special, out_special_result); end
      exp_count++;
      @(negedge clk);
      n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL inf_count got %0d want %0d", op_count, exp_count); end
   endtask

   task automatic test_zeros();
      @(negedge clk);
      drive(32'h0000_0000, 32'h4040_0000);
      @(negedge clk);
      drive(32'h8000_0000, 32'h8000_0000);
      n_cmp++; if ({out_special, out_special_result} !== {1'b1, 32'h4040_0000}) begin n_fail++; $display("FAIL zero_plus_num got %b %h want 1 40400000", out_special, out_special_result); end
      n_cmp++; if ({out_hidden_a, out_hidden_b} !== 2'b01) begin n_fail++; $display("FAIL zero_hidden got %b want 01", {out_hidden_a, out_hidden_b}); end
      exp_count++;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if ({out_special, out_special_result} !== {1'b1, 32'h8000_0000}) begin n_fail++; $display("FAIL negzero_sum got %b %h want 1 80000000", out_special, out_special_result); end
      exp_count++;
      @(negedge clk);
      n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL zero_count got %0d want %0d", op_count, exp_count); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h3F80_0001, 32'h3F80_0011);
      @(negedge clk);
      drive(32'h3F80_0002, 32'h3F80_0012);
      n_cmp++; if ({out_valid, in_ready, out_a} !== {2'b11, 32'h3F80_0001}) begin n_fail++; $display("FAIL bp_p1_held got %b %b %h want 1 1 3f800001", out_valid, in_ready, out_a); end
      @(negedge clk);
      drive(32'h3F80_0003, 32'h3F80_0013);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
      n_cmp++; if (out_a !== 32'h3F80_0001) begin n_fail++; $display("FAIL bp_stable got %h want 3f800001", out_a); end
      @(negedge clk);
      n_cmp++; if ({in_ready, out_a, out_b} !== {1'b0, 32'h3F80_0001, 32'h3F80_0011}) begin n_fail++; $display("FAIL bp_still_full got %b %h %h want 0 3f800001 3f800011", in_ready, out_a, out_b); end
      out_ready = 1'b1;
      @(negedge clk);
      exp_count++;
      n_cmp++; if ({in_ready, out_a, out_b} !== {1'b1, 32'h3F80_0002, 32'h3F80_0012}) begin n_fail++; $display("FAIL bp_p2 got %b %h %h want 1 3f800002 3f800012", in_ready, out_a, out_b); end
      @(negedge clk);
      exp_count++;
      in_valid = 1'b0;
      n_cmp++; if ({out_valid, out_a, out_b} !== {1'b1, 32'h3F80_0003, 32'h3F80_0013}) begin n_fail++; $display("FAIL bp_p3 got %b %h %h want 1 3f800003 3f800013", out_valid, out_a, out_b); end
      @(negedge clk);
      exp_count++;
      n_cmp++; if ({out_valid, op_count} !== {1'b0, exp_count}) begin n_fail++; $display("FAIL bp_drain got %b %0d want 0 %0d", out_valid, op_count, exp_count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic [98:0] exp_e;
      out_ready = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp_e = exp_q.pop_front();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_bubble item %0d got %b want 1", i, out_valid); end
            n_cmp++; if ({out_a, out_b, out_hidden_a, out_hidden_b, out_special, out_special_result} !== exp_e) begin
               n_fail++; $display("FAIL stream_item %0d got %h %h %b%b%b %h want %h", i, out_a, out_b, out_hidden_a, out_hidden_b, out_special, out_special_result, exp_e);
            end
            exp_count++;
         end
         if (i < 100) begin
            a = rand_op();
            b = rand_op();
            drive(a, b);
            exp_q.push_back(model(a, b));
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++; if ({out_valid, op_count} !== {1'b0, exp_count}) begin n_fail++; $display("FAIL stream_count got %b %0d want 0 %0d", out_valid, op_count, exp_count); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h4110_0000, 32'h4120_0000);
      @(negedge clk);
      drive(32'h4130_0000, 32'h4140_0000);
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_full got %b %b want 1 0", out_valid, in_ready); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if ({out_valid, in_ready, op_count} !== {2'b01, 16'd0}) begin n_fail++; $display("FAIL rstmid_async got %b %b %0d want 0 1 0", out_valid, in_ready, op_count); end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      exp_count = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, op_count} !== {2'b01, 16'd0}) begin n_fail++; $display("FAIL rstmid_stale got %b %b %0d want 0 1 0", out_valid, in_ready, op_count); end
   endtask

   task automatic test_denorm();
      @(negedge clk);
      drive(32'h0000_0001, 32'h3F80_0000);
      @(negedge clk);
      in_valid = 1'b0;
`ifdef FP_ADD_DENORM_FLUSH_EN
      n_cmp++; if ({out_special, out_special_result, out_a} !== {1'b1, 32'h3F80_0000, 32'h0}) begin n_fail++; $display("FAIL denorm_flush got %b %h %h want 1 3f800000 0", out_special, out_special_result, out_a); end
`else
      n_cmp++; if ({out_special, out_hidden_a, out_a} !== {2'b00, 32'h0000_0001}) begin n_fail++; $display("FAIL denorm_pass got %b %b %h want 0 0 00000001", out_special, out_hidden_a, out_a); end
`endif
      n_cmp++; if (out_hidden_b !== 1'b1) begin n_fail++; $display("FAIL denorm_hidden_b got %b want 1", out_hidden_b); end
      exp_count++;
      @(negedge clk);
      n_cmp++; if (op_count !== exp_count) begin n_fail++; $display("FAIL denorm_count got %0d want %0d", op_count, exp_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_infinities();
      test_zeros();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_denorm();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
